// File: rtl/ahbtoapb_pkg.sv
// Shared types and helpers for the AHB-to-APB bridge datapath.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents:
//   strb_width()/ptr_width()  width helpers; modules turn these into their own
//                             STRB_WIDTH / PTR_WIDTH localparams.
//   entry_ctrl_t              width-independent part of a queue entry.
//   size_to_strb()            HSIZE + address LSBs -> byte-lane strobes.
package ahbtoapb_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // A 1-entry queue still needs a 1-bit pointer so the storage can be indexed.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Address and write data depend on module parameters, so they are added
  // around this struct inside the queue module itself.
  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic       data_ok;
  } entry_ctrl_t;

  // Strobes for a transfer of 2**size bytes starting at byte lane addr_lsbs.
  // A transfer wider than the bus lights every lane; lanes shifted past the
  // top of the bus are dropped.
  function automatic logic [MAX_STRB_WIDTH-1:0] size_to_strb(
    input logic [2:0] size,
    input logic [2:0] addr_lsbs,
    input int         data_width
  );
    int          bus_bytes;
    int          xfer_bytes;
    logic [15:0] lane_mask;
    logic [15:0] base;
    bus_bytes  = data_width / 8;
    xfer_bytes = 1 << size;
    lane_mask  = 16'((1 << bus_bytes) - 1);
    if (xfer_bytes > bus_bytes) begin
      base = lane_mask;
    end else begin
      base = 16'(((1 << xfer_bytes) - 1) << addr_lsbs);
    end
    return MAX_STRB_WIDTH'(base & lane_mask);
  endfunction

endpackage

// File: rtl/ahbtoapb_strb_gen.sv
// APB byte-strobe generator from transfer size and address byte offset.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports:
//   i_write      transfer direction; reads always give zero strobes
//   i_size       AHB HSIZE encoding
//   i_addr_lsbs  byte offset of the transfer within the bus word
//   o_strb       one bit per byte lane
module ahbtoapb_strb_gen
  import ahbtoapb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int LSB_WIDTH  = $clog2(STRB_WIDTH)
) (
  input  logic                  i_write,
  input  logic [2:0]            i_size,
  input  logic [LSB_WIDTH-1:0]  i_addr_lsbs,
  output logic [STRB_WIDTH-1:0] o_strb
);

  logic [2:0] w_lsbs;

  always_comb begin
    w_lsbs = 3'(i_addr_lsbs);
    o_strb = i_write ? STRB_WIDTH'(size_to_strb(i_size, w_lsbs, DATA_WIDTH)) : '0;
  end

endmodule

// File: rtl/ahbtoapb_addrdata_queue.sv
// Address/data queue between the AHB-to-APB control FSM and the APB master port.
// Latency: APB outputs are combinational from the head entry; HRDATA one edge after latch_rd_data.
// Backpressure: enq_addr while full (and no effective deq) is dropped and sets sticky overflow.
//
// Ports:
//   HCLK, HRESETN                 clock, async active-low reset (flushes the queue)
//   HADDR/HWRITE/HSIZE, enq_addr  address phase, pushed as a new entry
//   HWDATA, enq_data              data phase, completes the newest write entry
//   deq                           pop head (only when head_valid)
//   PRDATA, latch_rd_data         read data captured into HRDATA
//   clr_overflow                  clears the sticky overflow flag
//   PADDR/PWDATA/PSTRB/PWRITE     head entry presented to APB (zero while empty)
//   head_valid/full/empty/count   queue status
module ahbtoapb_addrdata_queue
  import ahbtoapb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 2,
  localparam int STRB_WIDTH = strb_width(DATA_WIDTH),
  localparam int PTR_WIDTH  = ptr_width(DEPTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1,
  localparam int LSB_WIDTH  = $clog2(STRB_WIDTH)
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  enq_addr,
  input  logic                  enq_data,
  input  logic                  deq,
  input  logic                  latch_rd_data,
  input  logic                  clr_overflow,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  output logic                  PWRITE,
  output logic                  head_valid,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    entry_ctrl_t           ctrl;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  entry_t                r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic                  r_overflow;

  entry_t                w_head;
  entry_t                w_new;
  logic [PTR_WIDTH-1:0]  w_last_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_head_valid;
  logic                  w_deq_ok;
  logic                  w_enq_ok;
  logic                  w_data_ok;
  logic                  w_ovf_set;
  logic                  w_head_write;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  function automatic logic [PTR_WIDTH-1:0] ptr_dec(input logic [PTR_WIDTH-1:0] p);
    return (p == '0) ? PTR_WIDTH'(DEPTH - 1) : p - PTR_WIDTH'(1);
  endfunction

  always_comb begin
    w_full       = (r_count == CNT_WIDTH'(DEPTH));
    w_empty      = (r_count == '0);
    w_head       = r_mem[r_rd_ptr];
    w_head_valid = !w_empty && w_head.ctrl.data_ok;
    w_deq_ok     = deq && w_head_valid;
    // A full queue can still take a push when the head leaves on the same edge;
    // the freed slot is exactly the one wr_ptr points at.
    w_enq_ok     = enq_addr && (!w_full || w_deq_ok);
    w_ovf_set    = enq_addr && !w_enq_ok;
    // Data phase always belongs to the most recently pushed entry.
    w_last_ptr   = ptr_dec(r_wr_ptr);
    w_data_ok    = enq_data && !w_empty && !r_mem[w_last_ptr].ctrl.data_ok;

    w_new              = '0;
    w_new.addr         = HADDR;
    w_new.ctrl.write   = HWRITE;
    w_new.ctrl.size    = HSIZE;
    w_new.ctrl.data_ok = !HWRITE;
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_hrdata   <= '0;
      r_overflow <= 1'b0;
    end else begin
      // With DEPTH>1 w_last_ptr never equals r_wr_ptr; with DEPTH=1 the two
      // strobes cannot both be effective, so these writes never collide.
      if (w_data_ok) begin
        r_mem[w_last_ptr].wdata        <= HWDATA;
        r_mem[w_last_ptr].ctrl.data_ok <= 1'b1;
      end
      if (w_enq_ok) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_deq_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_enq_ok && !w_deq_ok) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (w_deq_ok && !w_enq_ok) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
      // Set wins over clear so a rejection in the clearing cycle is not lost.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
      if (latch_rd_data) begin
        r_hrdata <= PRDATA;
      end
    end
  end

  assign w_head_write = !w_empty && w_head.ctrl.write;

  ahbtoapb_strb_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strb_gen (
    .i_write     (w_head_write),
    .i_size      (w_head.ctrl.size),
    .i_addr_lsbs (w_head.addr[LSB_WIDTH-1:0]),
    .o_strb      (PSTRB)
  );

  assign PADDR      = w_empty ? '0 : w_head.addr;
  assign PWDATA     = w_empty ? '0 : w_head.wdata;
  assign PWRITE     = w_head_write;
  assign head_valid = w_head_valid;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign HRDATA     = r_hrdata;

endmodule

// File: tb/tb_ahbtoapb_addrdata_queue.sv
// Scoreboard bench for the AHB-to-APB address/data queue (64-bit data, depth 2).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The reference model is a plain queue of pending transfers.
module tb_ahbtoapb_addrdata_queue;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 2;
  localparam int SW    = DW / 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          HCLK;
  logic          HRESETN;
  logic [AW-1:0] HADDR;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic          enq_addr;
  logic          enq_data;
  logic          deq;
  logic          latch_rd_data;
  logic          clr_overflow;
  logic [DW-1:0] PRDATA;
  logic [DW-1:0] HRDATA;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic          PWRITE;
  logic          head_valid;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  ahbtoapb_addrdata_queue #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .HCLK          (HCLK),
    .HRESETN       (HRESETN),
    .HADDR         (HADDR),
    .HWRITE        (HWRITE),
    .HSIZE         (HSIZE),
    .HWDATA        (HWDATA),
    .enq_addr      (enq_addr),
    .enq_data      (enq_data),
    .deq           (deq),
    .latch_rd_data (latch_rd_data),
    .clr_overflow  (clr_overflow),
    .PRDATA        (PRDATA),
    .HRDATA        (HRDATA),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PSTRB         (PSTRB),
    .PWRITE        (PWRITE),
    .head_valid    (head_valid),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [AW-1:0] addr;
    bit            write;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    bit            data_ok;
  } m_entry_t;

  typedef struct {
    int            cnt;
    bit            hv;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    bit            chk_wdata;
    logic [SW-1:0] pstrb;
    bit            pwrite;
    logic [DW-1:0] hrdata;
    bit            ovf;
  } exp_t;

  m_entry_t      mq[$];
  exp_t          exp_q[$];
  bit            m_ovf;
  logic [DW-1:0] m_hrdata;
  int            checks;
  int            failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte lanes touched by the head transfer, counted lane by lane.
  function automatic logic [SW-1:0] model_strb(input m_entry_t e);
    logic [SW-1:0] s;
    int            nb;
    int            lsb;
    s = '0;
    if (!e.write) return s;
    nb = 1 << e.size;
    if (nb > SW) return '1;
    lsb = int'(e.addr[2:0]);
    for (int b = 0; b < SW; b++) begin
      if (b >= lsb && b < lsb + nb) s[b] = 1'b1;
    end
    return s;
  endfunction

  function automatic exp_t snapshot();
    exp_t x;
    x.cnt    = mq.size();
    x.hrdata = m_hrdata;
    x.ovf    = m_ovf;
    if (mq.size() == 0) begin
      x.hv        = 1'b0;
      x.paddr     = '0;
      x.pwdata    = '0;
      x.chk_wdata = 1'b1;
      x.pstrb     = '0;
      x.pwrite    = 1'b0;
    end else begin
      x.hv        = mq[0].data_ok;
      x.paddr     = mq[0].addr;
      x.pwdata    = mq[0].wdata;
      x.chk_wdata = mq[0].write && mq[0].data_ok;
      x.pstrb     = model_strb(mq[0]);
      x.pwrite    = mq[0].write;
    end
    return x;
  endfunction

  task automatic check_outputs(input exp_t x, input string tag);
    chk({tag, "_count"}, 64'(count), 64'(x.cnt));
    chk({tag, "_empty"}, 64'(empty), 64'(x.cnt == 0));
    chk({tag, "_full"}, 64'(full), 64'(x.cnt == DEPTH));
    chk({tag, "_head_valid"}, 64'(head_valid), 64'(x.hv));
    chk({tag, "_paddr"}, 64'(PADDR), 64'(x.paddr));
    chk({tag, "_pstrb"}, 64'(PSTRB), 64'(x.pstrb));
    chk({tag, "_pwrite"}, 64'(PWRITE), 64'(x.pwrite));
    chk({tag, "_hrdata"}, 64'(HRDATA), 64'(x.hrdata));
    chk({tag, "_overflow"}, 64'(overflow), 64'(x.ovf));
    if (x.chk_wdata) chk({tag, "_pwdata"}, 64'(PWDATA), 64'(x.pwdata));
  endtask

  task automatic model_step(input bit ea, input bit ed, input bit dq, input bit lr, input bit cl,
                            input logic [AW-1:0] a, input bit w, input logic [2:0] s,
                            input logic [DW-1:0] wd, input logic [DW-1:0] pr);
    bit       hv;
    bit       dq_ok;
    bit       enq_ok;
    m_entry_t e;
    hv     = (mq.size() > 0) && mq[0].data_ok;
    dq_ok  = dq && hv;
    enq_ok = ea && ((mq.size() < DEPTH) || dq_ok);
    if (ed && mq.size() > 0 && !mq[mq.size()-1].data_ok) begin
      e = mq[mq.size()-1];
      e.wdata = wd;
      e.data_ok = 1'b1;
      mq[mq.size()-1] = e;
    end
    if (dq_ok) void'(mq.pop_front());
    if (enq_ok) begin
      e.addr = a;
      e.write = w;
      e.size = s;
      e.wdata = '0;
      e.data_ok = !w;
      mq.push_back(e);
    end
    if (ea && !enq_ok) m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
    if (lr) m_hrdata = pr;
  endtask

  task automatic cyc(input bit ea, input bit ed, input bit dq, input bit lr, input bit cl,
                     input logic [AW-1:0] a, input bit w, input logic [2:0] s,
                     input logic [DW-1:0] wd, input logic [DW-1:0] pr);
    @(negedge HCLK);
    enq_addr      = ea;
    enq_data      = ed;
    deq           = dq;
    latch_rd_data = lr;
    clr_overflow  = cl;
    HADDR         = a;
    HWRITE        = w;
    HSIZE         = s;
    HWDATA        = wd;
    PRDATA        = pr;
    model_step(ea, ed, dq, lr, cl, a, w, s, wd, pr);
    exp_q.push_back(snapshot());
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd0, '0, '0);
  endtask

  // Let the monitor consume the expectation for the edge just driven.
  task automatic sync();
    @(posedge HCLK);
    #2;
  endtask

  // Monitor: one expectation per driven edge, compared after that edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge HCLK);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check_outputs(x, "sb");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    m_ovf = 1'b0;
    m_hrdata = '0;
    HRESETN = 1'b0;
    enq_addr = 1'b0; enq_data = 1'b0; deq = 1'b0; latch_rd_data = 1'b0; clr_overflow = 1'b0;
    HADDR = '0; HWRITE = 1'b0; HSIZE = '0; HWDATA = '0; PRDATA = '0;

    repeat (2) @(posedge HCLK);
    #1;
    check_outputs(snapshot(), "reset");
    @(negedge HCLK);
    HRESETN = 1'b1;
    idle();

    // Write completes one edge after its data phase.
    cyc(1, 0, 0, 0, 0, 32'h100, 1, 3'd2, '0, '0);
    cyc(0, 1, 0, 0, 0, '0, 0, 3'd0, 64'hDEADBEEF, '0);
    sync();
    chk("tp_write_paddr", 64'(PADDR), 64'h100);
    chk("tp_write_pwdata", 64'(PWDATA), 64'hDEADBEEF);
    chk("tp_write_pstrb", 64'(PSTRB), 64'h0F);
    chk("tp_write_hv", 64'(head_valid), 64'h1);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);

    // Halfword write at byte offset 6, then a read.
    cyc(1, 0, 0, 0, 0, 32'h206, 1, 3'd1, '0, '0);
    cyc(0, 1, 0, 0, 0, '0, 0, 3'd0, 64'h55AA, '0);
    sync();
    chk("tp_hword_pstrb", 64'(PSTRB), 64'hC0);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);
    cyc(1, 0, 0, 0, 0, 32'h300, 0, 3'd2, '0, '0);
    sync();
    chk("tp_read_pstrb", 64'(PSTRB), 64'h00);
    chk("tp_read_pwrite", 64'(PWRITE), 64'h0);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);

    // Fill, overflow, set-beats-clear, push with simultaneous pop.
    cyc(1, 0, 0, 0, 0, 32'h10, 0, 3'd2, '0, '0);
    cyc(1, 0, 0, 0, 0, 32'h14, 0, 3'd2, '0, '0);
    cyc(1, 0, 0, 0, 0, 32'h18, 0, 3'd2, '0, '0);
    sync();
    chk("tp_ovf_flag", 64'(overflow), 64'h1);
    chk("tp_ovf_count", 64'(count), 64'h2);
    cyc(1, 0, 0, 0, 1, 32'h20, 0, 3'd2, '0, '0);
    sync();
    chk("tp_ovf_set_wins", 64'(overflow), 64'h1);
    cyc(1, 0, 1, 0, 0, 32'h1C, 0, 3'd2, '0, '0);
    sync();
    chk("tp_full_deq_count", 64'(count), 64'h2);
    chk("tp_full_deq_paddr", 64'(PADDR), 64'h14);
    cyc(0, 0, 0, 0, 1, '0, 0, 3'd0, '0, '0);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);

    // Pipelined: address of B with data of A.
    cyc(1, 0, 0, 0, 0, 32'h400, 1, 3'd2, '0, '0);
    cyc(1, 1, 0, 0, 0, 32'h404, 1, 3'd2, 64'h1111, '0);
    sync();
    chk("tp_pipe_hv_a", 64'(head_valid), 64'h1);
    chk("tp_pipe_pwdata_a", 64'(PWDATA), 64'h1111);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);
    sync();
    chk("tp_pipe_paddr_b", 64'(PADDR), 64'h404);
    chk("tp_pipe_hv_b", 64'(head_valid), 64'h0);
    cyc(0, 1, 0, 0, 0, '0, 0, 3'd0, 64'h2222, '0);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);

    // Read data capture and hold; deq on empty.
    cyc(0, 0, 0, 1, 0, '0, 0, 3'd0, '0, 64'h12345678);
    cyc(0, 0, 0, 0, 0, '0, 0, 3'd0, '0, 64'hFFFF0000);
    sync();
    chk("tp_hrdata_hold", 64'(HRDATA), 64'h12345678);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);
    sync();
    chk("tp_deq_empty_count", 64'(count), 64'h0);
    chk("tp_deq_empty_flag", 64'(empty), 64'h1);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, $urandom,
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
          {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle();

    // Asynchronous reset with entries, read data and overflow all live.
    cyc(0, 1, 1, 0, 1, '0, 0, 3'd0, 64'h3, '0);
    cyc(0, 1, 1, 0, 0, '0, 0, 3'd0, 64'h4, '0);
    cyc(1, 0, 0, 0, 0, 32'h500, 1, 3'd2, '0, '0);
    cyc(1, 0, 0, 1, 0, 32'h504, 0, 3'd2, '0, 64'hCAFE);
    cyc(1, 0, 0, 0, 0, 32'h508, 0, 3'd2, '0, '0);
    idle();
    sync();
    #1;
    HRESETN = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_hrdata = '0;
    check_outputs(snapshot(), "async_rst");
    enq_addr = 1'b1;
    HADDR = 32'h600;
    repeat (2) @(posedge HCLK);
    #1;
    check_outputs(snapshot(), "in_rst");
    enq_addr = 1'b0;
    @(negedge HCLK);
    HRESETN = 1'b1;
    idle();
    idle();
    cyc(1, 0, 0, 0, 0, 32'h700, 0, 3'd3, '0, '0);
    cyc(0, 0, 1, 0, 0, '0, 0, 3'd0, '0, '0);
    idle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge HCLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
